// File: rtl/data_mem_ctrl.sv
// Single-port data memory for the core's load/store path: valid/ready requests, byte enables,
// range checking, a registered one-cycle response and an optional post-reset clear. DMEM_PARITY_EN adds byte parity.
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
`ifdef DMEM_PARITY_EN
  input  logic                  inj_par_err,
`endif
  output logic                  init_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               accept, in_range;
  logic [IDX_W-1:0]   idx, clr_idx;
  logic               vld_p0_q, we_p0_q, rng_p0_q;
  logic [IDX_W-1:0]   idx_p0_q;
  logic [DATA_W-1:0]  rd_word;
  logic               rd_ok, par_bad;
  logic               rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0]      par_q [DEPTH];

  function automatic logic par_mismatch(input logic [DATA_W-1:0] w, input logic [NB-1:0] p);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < NB; b++) bad = bad | ((^w[8*b +: 8]) != p[b]);
    return bad;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) state_d = S_RUN;
    end
  end

  // reset gates ready so nothing is accepted while reset is held, even when no clear runs
  always_comb begin
    req_ready = (state_q == S_RUN) & ~reset;
    init_busy = (state_q == S_CLEAR);
  end

  assign accept   = req_valid & req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_A;
  assign idx      = req_addr[IDX_W-1:0];
  assign clr_idx  = cnt_q[IDX_W-1:0];

  // stage p0: writes commit on the accept edge; reads are captured for the response stage
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_idx] <= '0;
`ifdef DMEM_PARITY_EN
      par_q[clr_idx] <= '0;
`endif
    end else if (accept && req_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
          par_q[idx][b] <= (^req_wdata[8*b +: 8]) ^ inj_par_err;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p0_q <= 1'b0;
    else       vld_p0_q <= accept;
  end

  always_ff @(posedge clk) begin
    we_p0_q  <= req_we;
    rng_p0_q <= in_range;
    idx_p0_q <= idx;
  end

  assign rd_word = mem_q[idx_p0_q];
  assign rd_ok   = vld_p0_q & ~we_p0_q & rng_p0_q;
`ifdef DMEM_PARITY_EN
  assign par_bad = rd_ok & par_mismatch(rd_word, par_q[idx_p0_q]);
`else
  assign par_bad = 1'b0;
`endif

  // stage p1: registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= vld_p0_q;
      rsp_rdata_q <= rd_ok ? rd_word : '0;
      rsp_err_q   <= vld_p0_q & (~rng_p0_q | par_bad);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DEPTH=256, 16-bit words, clear on reset).
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_err, init_busy, inj_par_err;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef DMEM_PARITY_EN
    .inj_par_err(inj_par_err),
`endif
    .init_busy(init_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated request; returns ready-at-issue and rsp_valid after the accept edge, response edge and one after.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be,
                     input logic inj, output logic [3:0] hs, output logic [15:0] d, output logic e);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be; inj_par_err = inj;
    hs[3] = req_ready;
    tick;
    req_valid = 1'b0; req_we = 1'b0; inj_par_err = 1'b0;
    hs[2] = rsp_valid;
    tick;
    hs[1] = rsp_valid; d = rsp_rdata; e = rsp_err;
    tick;
    hs[0] = rsp_valid;
  endtask

  task automatic count_busy(output int n, output logic rdy_seen);
    n = 0; rdy_seen = 1'b0;
    while (init_busy === 1'b1 && n < 1000) begin
      if (req_ready !== 1'b0) rdy_seen = 1'b1;
      n++;
      tick;
    end
  endtask

  task automatic test_reset;
    int n; logic rdy_seen; logic [3:0] hs; logic [15:0] d; logic e;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; inj_par_err = 1'b0;
    tick; tick;
    checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== 18'h0) begin errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b, expected all zero", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if ({req_ready, init_busy} !== 2'b01) begin errors++;
      $display("FAIL reset_ready_busy: got ready=%b busy=%b, expected ready=0 busy=1", req_ready, init_busy); end
    reset = 1'b0;
    count_busy(n, rdy_seen);
    checks++; if (n !== 256) begin errors++; $display("FAIL clear_len: got %0d busy cycles, expected 256", n); end
    checks++; if ({rdy_seen, req_ready} !== 2'b01) begin errors++;
      $display("FAIL clear_ready: ready during clear=%b ready after=%b, expected 0 and 1", rdy_seen, req_ready); end
    txn(1'b0, 16'h00FF, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({hs, d, e} !== {4'b1010, 16'h0000, 1'b0}) begin errors++;
      $display("FAIL read_ff_cleared: got hs=%b data=%h err=%b, expected hs=1010 data=0000 err=0", hs, d, e); end
  endtask

  task automatic test_write_read;
    logic v_a, v_b, e_b, v_c, e_c, v_d; logic [15:0] d_b, d_c;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'hBEEF; req_be = 2'b11;
    tick;
    req_we = 1'b0;
    v_a = rsp_valid;
    tick;
    req_valid = 1'b0;
    v_b = rsp_valid; d_b = rsp_rdata; e_b = rsp_err;
    tick;
    v_c = rsp_valid; d_c = rsp_rdata; e_c = rsp_err;
    tick;
    v_d = rsp_valid;
    checks++; if ({v_a, v_b, v_c, v_d} !== 4'b0110) begin errors++;
      $display("FAIL b2b_pulses: got %b%b%b%b, expected 0110", v_a, v_b, v_c, v_d); end
    checks++; if ({d_b, e_b} !== {16'h0000, 1'b0}) begin errors++;
      $display("FAIL b2b_wr_rsp: got data=%h err=%b, expected 0000 0", d_b, e_b); end
    checks++; if ({d_c, e_c} !== {16'hBEEF, 1'b0}) begin errors++;
      $display("FAIL b2b_rd_rsp: got data=%h err=%b, expected beef 0", d_c, e_c); end
  endtask

  task automatic test_byte_enable;
    logic [3:0] hs; logic [15:0] d; logic e;
    txn(1'b1, 16'd7, 16'h1234, 2'b11, 1'b0, hs, d, e);
    txn(1'b1, 16'd7, 16'hAB00, 2'b10, 1'b0, hs, d, e);
    txn(1'b0, 16'd7, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({hs, d, e} !== {4'b1010, 16'hAB34, 1'b0}) begin errors++;
      $display("FAIL byte_en: got hs=%b data=%h err=%b, expected 1010 ab34 0", hs, d, e); end
    txn(1'b1, 16'd7, 16'hFFFF, 2'b00, 1'b0, hs, d, e);
    txn(1'b0, 16'd7, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if (d !== 16'hAB34) begin errors++; $display("FAIL be_zero: got %h, expected ab34", d); end
  endtask

  task automatic test_out_of_range;
    logic [3:0] hs; logic [15:0] d; logic e;
    txn(1'b1, 16'd256, 16'h5555, 2'b11, 1'b0, hs, d, e);
    checks++; if ({hs, d, e} !== {4'b1010, 16'h0000, 1'b1}) begin errors++;
      $display("FAIL oor_write: got hs=%b data=%h err=%b, expected 1010 0000 1", hs, d, e); end
    txn(1'b0, 16'd256, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({hs, d, e} !== {4'b1010, 16'h0000, 1'b1}) begin errors++;
      $display("FAIL oor_read: got hs=%b data=%h err=%b, expected 1010 0000 1", hs, d, e); end
    txn(1'b0, 16'd0, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({d, e} !== {16'h0000, 1'b0}) begin errors++;
      $display("FAIL alias_addr0: got data=%h err=%b, expected 0000 0", d, e); end
    txn(1'b0, 16'hFFFF, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({d, e} !== {16'h0000, 1'b1}) begin errors++;
      $display("FAIL oor_ffff: got data=%h err=%b, expected 0000 1", d, e); end
  endtask

  task automatic test_reset_mid_request;
    int n; logic rdy_seen; logic v1, v2; logic [3:0] hs; logic [15:0] d; logic e;
    txn(1'b1, 16'd9, 16'h4321, 2'b11, 1'b0, hs, d, e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd9;
    tick;
    req_valid = 1'b0; reset = 1'b1;
    tick;
    v1 = rsp_valid;
    tick;
    v2 = rsp_valid;
    reset = 1'b0;
    checks++; if ({v1, v2} !== 2'b00) begin errors++;
      $display("FAIL rst_suppress: got rsp_valid %b then %b, expected 0 0", v1, v2); end
    count_busy(n, rdy_seen);
    checks++; if ({n, rdy_seen} !== {32'd256, 1'b0}) begin errors++;
      $display("FAIL rst_req_clear: got %0d busy cycles ready_seen=%b, expected 256 0", n, rdy_seen); end
    txn(1'b0, 16'd9, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({hs, d} !== {4'b1010, 16'h0000}) begin errors++;
      $display("FAIL post_clear_9: got hs=%b data=%h, expected 1010 0000", hs, d); end
  endtask

  task automatic test_reset_mid_clear;
    int n; logic rdy_seen;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick;
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL clear_at_100: got busy=%b, expected 1", init_busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    count_busy(n, rdy_seen);
    checks++; if (n !== 256) begin errors++; $display("FAIL restart_clear: got %0d busy cycles, expected 256", n); end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity;
    logic [3:0] hs; logic [15:0] d; logic e;
    txn(1'b1, 16'd3, 16'h00FF, 2'b11, 1'b1, hs, d, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL par_wr_err: got %b, expected 0", e); end
    txn(1'b0, 16'd3, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({d, e} !== {16'h00FF, 1'b1}) begin errors++;
      $display("FAIL par_inj: got data=%h err=%b, expected 00ff 1", d, e); end
    txn(1'b1, 16'd3, 16'h00FF, 2'b11, 1'b0, hs, d, e);
    txn(1'b0, 16'd3, 16'h0, 2'b00, 1'b0, hs, d, e);
    checks++; if ({d, e} !== {16'h00FF, 1'b0}) begin errors++;
      $display("FAIL par_clean: got data=%h err=%b, expected 00ff 0", d, e); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_read;
    test_byte_enable;
    test_out_of_range;
`ifdef DMEM_PARITY_EN
    test_parity;
`endif
    test_reset_mid_request;
    test_reset_mid_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
